// File: rtl/multicycle_control_fsm.sv
// Multicycle ARM-subset control unit: sequences fetch/decode/execute/memory/writeback,
// owns the condition flags and gates every architectural write with the latched condition.
module multicycle_control_fsm #(
  parameter int MEM_LAT   = 1,
  parameter int ALUCTRL_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [3:0]           Cond,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           Flags,
  output logic [3:0]           State
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_condex;
  logic [3:0]       r_flags;
  logic             w_wait_st;
  logic             w_last;
  logic             w_condex;
  logic             w_flag_upd;
  logic [1:0]       w_alu_cmd;
  logic [1:0]       w_alu_ctl;
  logic             w_pcw;
  logic             w_irw;
  logic             w_rw;
  logic             w_mw;

  // Flag vector is {N,Z,C,V}; cond 1111 is treated as never-execute.
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'b0000: cond_eval = z;
      4'b0001: cond_eval = ~z;
      4'b0010: cond_eval = cf;
      4'b0011: cond_eval = ~cf;
      4'b0100: cond_eval = n;
      4'b0101: cond_eval = ~n;
      4'b0110: cond_eval = v;
      4'b0111: cond_eval = ~v;
      4'b1000: cond_eval = cf & ~z;
      4'b1001: cond_eval = ~cf | z;
      4'b1010: cond_eval = (n == v);
      4'b1011: cond_eval = (n != v);
      4'b1100: cond_eval = ~z & (n == v);
      4'b1101: cond_eval = z | (n != v);
      4'b1110: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] cmd_decode(input logic [3:0] cmd);
    case (cmd)
      4'b0100: cmd_decode = ALU_ADD;
      4'b0010: cmd_decode = ALU_SUB;
      4'b0000: cmd_decode = ALU_AND;
      4'b1100: cmd_decode = ALU_ORR;
      default: cmd_decode = ALU_ADD;
    endcase
  endfunction

  always_comb begin
    w_wait_st  = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    w_last     = ~w_wait_st || (r_cnt == CNT_LAST);
    w_condex   = cond_eval(Cond, r_flags);
    w_alu_cmd  = cmd_decode(Funct[4:1]);
    w_flag_upd = ((r_state == S_EXECR) || (r_state == S_EXECI)) && Funct[0] && r_condex;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_cnt    <= '0;
      r_condex <= 1'b0;
      r_flags  <= 4'b0000;
    end else begin
      r_state <= w_next;
      if (w_wait_st && !w_last) r_cnt <= r_cnt + 1'b1;
      else                      r_cnt <= '0;
      if (r_state == S_DECODE) r_condex <= w_condex;
      if (w_flag_upd) begin
        r_flags[3:2] <= ALUFlags[3:2];
        // Logical ops leave carry and overflow untouched
        if (w_alu_cmd == ALU_ADD || w_alu_cmd == ALU_SUB) r_flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_pcw     = 1'b0;
    w_irw     = 1'b0;
    w_rw      = 1'b0;
    w_mw      = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    w_alu_ctl = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_irw     = w_last;
        w_pcw     = w_last;
        if (w_last) w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (Op)
          2'b00:   w_next = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        w_next  = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
        if (w_last) w_next = S_MEMWB;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        w_mw   = r_condex & w_last;
        if (w_last) w_next = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB   = (r_state == S_EXECI) ? 2'b01 : 2'b00;
        w_alu_ctl = w_alu_cmd;
        w_next    = S_ALUWB;
      end
      S_MEMWB, S_ALUWB: begin
        ResultSrc = (r_state == S_MEMWB) ? 2'b01 : 2'b00;
        if (Rd == 4'd15) w_pcw = r_condex;
        else             w_rw  = r_condex;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        w_pcw     = r_condex;
        w_next    = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Write strobes are held low for as long as reset is asserted.
  always_comb begin
    PCWrite    = w_pcw & ~reset;
    IRWrite    = w_irw & ~reset;
    RegWrite   = w_rw & ~reset;
    MemWrite   = w_mw & ~reset;
    ALUControl = ALUCTRL_W'(w_alu_ctl);
    ImmSrc     = Op;
    RegSrc     = {Op == 2'b01, Op == 2'b10};
    Flags      = r_flags;
    State      = r_state;
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: each issued instruction expands into an expected per-cycle trace;
// a negedge monitor pops and compares against the DUT outputs.
module tb_multicycle_control_fsm;

  localparam int L  = 3;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    Op;
  logic [5:0]    Funct;
  logic [3:0]    Rd, Cond, ALUFlags;
  logic          PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
  logic [1:0]    ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [AW-1:0] ALUControl;
  logic [3:0]    Flags, State;

  multicycle_control_fsm #(.MEM_LAT(L), .ALUCTRL_W(AW)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .Flags(Flags), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] e;
    logic [24:0] m;
  } exp_t;

  exp_t       q[$];
  int         ncmp = 0;
  int         nbad = 0;
  logic [3:0] mflags;
  logic [1:0] cur_op;

  // ARM conditions: pairs share a base test, odd codes invert it; 1111 is never.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic int cmd_code(input logic [3:0] cmd);
    if (cmd == 4'd4)  return 0;
    if (cmd == 4'd2)  return 1;
    if (cmd == 4'd0)  return 2;
    if (cmd == 4'd12) return 3;
    return 0;
  endfunction

  function automatic logic [24:0] act_vec();
    return {State, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
            ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, Flags};
  endfunction

  // Negative mux-select arguments mean "don't care" in that state.
  task automatic push(input int st, input bit pcw, input bit irw, input bit rw, input bit mw,
                      input int adr, input int srca, input int srcb, input int res, input int ctl);
    exp_t x;
    x.e = {4'(st), pcw, irw, rw, mw,
           (adr < 0) ? 1'b0 : 1'(adr), (srca < 0) ? 1'b0 : 1'(srca),
           (srcb < 0) ? 2'b0 : 2'(srcb), (res < 0) ? 2'b0 : 2'(res),
           cur_op, {cur_op == 2'd1, cur_op == 2'd2},
           (ctl < 0) ? 3'b0 : 3'(ctl), mflags};
    x.m = {4'hf, 4'hf,
           (adr < 0) ? 1'b0 : 1'b1, (srca < 0) ? 1'b0 : 1'b1,
           (srcb < 0) ? 2'b00 : 2'b11, (res < 0) ? 2'b00 : 2'b11,
           2'b11, 2'b11, (ctl < 0) ? 3'b000 : 3'b111, 4'hf};
    q.push_back(x);
  endtask

  task automatic gen(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                     input logic [3:0] cd, input logic [3:0] af, input bit wait_all);
    int n0, n, ctl;
    bit cex;
    Op = op; Funct = fn; Rd = rd; Cond = cd; ALUFlags = af;
    cur_op = op;
    n0  = q.size();
    cex = cond_ok(cd, mflags);
    ctl = cmd_code(fn[4:1]);
    for (int k = 0; k < L; k++) push(0, k == L-1, k == L-1, 0, 0, 0, 1, 2, 2, 0);
    push(1, 0, 0, 0, 0, -1, 1, 2, -1, 0);
    case (op)
      2'd0: begin
        push(fn[5] ? 7 : 6, 0, 0, 0, 0, -1, -1, fn[5] ? 1 : 0, -1, ctl);
        if (fn[0] && cex) begin
          mflags[3:2] = af[3:2];
          if (ctl <= 1) mflags[1:0] = af[1:0];
        end
        push(8, cex && rd == 15, 0, cex && rd != 15, 0, -1, -1, -1, 0, -1);
      end
      2'd1: begin
        push(2, 0, 0, 0, 0, -1, 0, 1, -1, 0);
        if (fn[0]) begin
          for (int k = 0; k < L; k++) push(3, 0, 0, 0, 0, 1, -1, -1, -1, -1);
          push(4, cex && rd == 15, 0, cex && rd != 15, 0, -1, -1, -1, 1, -1);
        end else begin
          for (int k = 0; k < L; k++) push(5, 0, 0, 0, cex && k == L-1, 1, -1, -1, -1, -1);
        end
      end
      2'd2: push(9, cex, 0, 0, 0, -1, 0, 1, 2, 0);
      default: ;
    endcase
    n = q.size() - n0;
    if (wait_all) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    ncmp++;
    if (act !== req) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && q.size() > 0) begin
        exp_t x;
        logic [24:0] a;
        x = q.pop_front();
        a = act_vec();
        ncmp++;
        if (((a ^ x.e) & x.m) != 25'd0) begin
          nbad++;
          $display("FAIL trace t=%0t: got %h expected %h (mask %h)", $time, a & x.m, x.e, x.m);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    Op = 2'd0; Funct = 6'd0; Rd = 4'd0; Cond = 4'd14; ALUFlags = 4'd0;
    mflags = 4'd0; cur_op = 2'd0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_state", 8'(State), 8'd0);
    check("rst_flags", 8'(Flags), 8'd0);
    check("rst_strobes", 8'({PCWrite, IRWrite, RegWrite, MemWrite}), 8'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    gen(2'd0, 6'b001001, 4'd3,  4'd14, 4'b0100, 1);  // ADDS r3
    gen(2'd1, 6'b011001, 4'd5,  4'd14, 4'b0000, 1);  // LDR
    gen(2'd2, 6'b000000, 4'd0,  4'd0,  4'b0000, 1);  // BEQ, Z=1
    gen(2'd0, 6'b001001, 4'd1,  4'd14, 4'b0000, 1);  // ADDS clearing Z
    gen(2'd2, 6'b000000, 4'd0,  4'd0,  4'b0000, 1);  // BEQ, Z=0
    gen(2'd0, 6'b001001, 4'd1,  4'd14, 4'b0100, 1);  // set Z
    gen(2'd1, 6'b011000, 4'd2,  4'd1,  4'b0000, 1);  // STRNE, not taken
    gen(2'd3, 6'b111111, 4'd7,  4'd14, 4'b1111, 1);  // illegal op
    gen(2'd0, 6'b000100, 4'd15, 4'd14, 4'b0000, 1);  // SUB pc
    gen(2'd0, 6'b000101, 4'd4,  4'd15, 4'b1111, 1);  // SUBS never
    gen(2'd0, 6'b100001, 4'd6,  4'd14, 4'b1011, 1);  // ANDS imm: C,V hold
    gen(2'd1, 6'b011000, 4'd2,  4'd14, 4'b0000, 1);  // STR AL
    gen(2'd0, 6'b001001, 4'd1,  4'd14, 4'b1111, 1);  // flags 1111 before reset

    // Async reset in the middle of a MEMRD wait
    gen(2'd1, 6'b011001, 4'd5, 4'd14, 4'b0000, 0);
    repeat (L + 3) @(posedge clk);
    #2;
    check("memrd_reached", 8'(State), 8'd3);
    reset = 1'b1;
    #1;
    check("async_state", 8'(State), 8'd0);
    check("async_flags", 8'(Flags), 8'd0);
    check("async_strobes", 8'({PCWrite, IRWrite, RegWrite, MemWrite}), 8'd0);
    q.delete();
    mflags = 4'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    gen(2'd1, 6'b011001, 4'd9, 4'd14, 4'b0000, 1);   // LDR after reset, count restarts
    for (int i = 0; i < 300; i++) begin
      logic [1:0] op;
      logic [5:0] fn;
      logic [3:0] cd;
      op = 2'($urandom_range(0, 3));
      fn = 6'($urandom);
      if ($urandom_range(0, 3) == 0) fn[4:1] = 4'($urandom_range(0, 1) == 0 ? 4 : 2);
      cd = ($urandom_range(0, 2) == 0) ? 4'd14 : 4'($urandom);
      gen(op, fn, 4'($urandom), cd, 4'($urandom), 1);
    end
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 8'(q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Parametrised multicycle successor to the single-cycle main decoder. Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Owns the condition-flag register and conditional-execution gating.
- Supports memories with configurable latency.
- Drives every datapath strobe and mux select of the multicycle ARM-subset datapath.

Parameters:
- MEM_LAT, 1, cycles per memory access (>=1) in FETCH, MEMRD and MEMWR.
- ALUCTRL_W, 2, width of ALUControl (>=2); codes are zero-extended.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- Op  in  2  instruction[27:26]
- Funct  in  6  instruction[25:20] (I, cmd[3:0], S/L)
- Rd  in  4  destination register
- Cond  in  4  instruction[31:28]
- ALUFlags  in  4  {N,Z,C,V} from ALU
- PCWrite  out  1  PC register enable
- IRWrite  out  1  instruction register enable
- RegWrite  out  1  register file write enable
- MemWrite  out  1  data memory write enable
- AdrSrc  out  1  0=PC, 1=ALUOut
- ALUSrcA  out  1  0=Rn, 1=PC
- ALUSrcB  out  2  00=Rm, 01=ExtImm, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=ReadData, 10=ALUResult
- ImmSrc  out  2  equals Op
- RegSrc  out  2  bit0=(Op==10), bit1=(Op==01)
- ALUControl  out  ALUCTRL_W  00 ADD, 01 SUB, 10 AND, 11 ORR
- Flags  out  4  registered {N,Z,C,V}
- State  out  4  current state code

Behaviour:
- Reset (async):
  - State=FETCH(0), Flags=0000, wait counter=0, CondExReg=0.
  - While reset is high, PCWrite, IRWrite, RegWrite and MemWrite are forced 0.
- States and codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9.
- Wait counter (FETCH, MEMRD, MEMWR):
  - Counts 0..MEM_LAT-1.
  - State advances only when count==MEM_LAT-1; the counter then clears.
  - Strobes in these states (IRWrite, FETCH PCWrite, MemWrite) assert only on the final count cycle.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: Op=00 and Funct[5]=0 -> EXECR; Op=00 and Funct[5]=1 -> EXECI; Op=01 -> MEMADR; Op=10 -> BRANCH; Op=11 (illegal) -> FETCH with no writes.
  - MEMADR: Funct[0]=1 -> MEMRD, else -> MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXECR / EXECI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
- Per-state outputs (Moore; unlisted strobes 0):
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, IRWrite=1, PCWrite=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD.
  - MEMRD / MEMWR: AdrSrc=1. MemWrite=CondExReg in MEMWR.
  - MEMWB: ResultSrc=01.
  - EXECR: ALUSrcB=00. EXECI: ALUSrcB=01. Both: ALUControl decoded from Funct[4:1].
  - ALUWB: ResultSrc=00.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, ResultSrc=10, PCWrite=CondExReg.
- Command decode, Funct[4:1]: 0100->ADD, 0010->SUB, 0000->AND, 1100->ORR; any other cmd executes as ADD.
- Conditional execution:
  - CondEx is evaluated from Cond against the Flags register using the standard ARM table (EQ..LE, AL=1110); Cond=1111 evaluates false.
  - CondEx is latched into CondExReg in DECODE and used by all later states of that instruction, so a flag update in EXEC does not alter the same instruction's writes.
- Writeback (MEMWB / ALUWB):
  - Rd!=15: RegWrite=CondExReg.
  - Rd==15: PCWrite=CondExReg and RegWrite=0.
- Flag update, last cycle of EXECR/EXECI, when Funct[0]=1 and CondExReg=1:
  - N,Z load from ALUFlags.
  - C,V load only for ADD or SUB.
  - Otherwise Flags hold.
- Inputs must be stable from DECODE until the return to FETCH; Op, Funct and Rd are sampled combinationally.

Test Plan:
1. Reset asserted during MEMRD with MEM_LAT=3, mid-count -> State=0 immediately, all strobes 0, Flags=0000; after release, FETCH restarts at count 0.
2. ADDS reg: Op=00, Funct=001001, Cond=1110, Rd=3, ALUFlags=0100 -> State 0,1,6,8,0; Flags=0100 after EXECR; one RegWrite pulse in ALUWB; ALUControl=00.
3. LDR, MEM_LAT=3: Op=01, Funct=011001 -> FETCH lasts 3 cycles with IRWrite/PCWrite only on cycle 3; then 1,2; MEMRD for 3 cycles with AdrSrc=1; RegWrite in MEMWB with ResultSrc=01.
4. BEQ: Op=10, Cond=0000. With Flags.Z=0 -> states 0,1,9,0, no PCWrite in BRANCH. With Z=1 -> exactly one PCWrite in BRANCH.
5. STR with Cond=0001 (NE) and Z=1 -> states 0,1,2,5,0, MemWrite never asserted. Op=11 -> states 0,1,0, no writes.
6. SUB with Rd=15, AL -> PCWrite=1 and RegWrite=0 in ALUWB, ALUControl=01. SUBS with Cond=1111 -> Flags unchanged.
